// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the serial shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_MSB_FIRST = 1'b1;
  localparam logic DIR_LSB_FIRST = 1'b0;

endpackage

// File: rtl/shift_seq_ctrl_shift_dp.sv
// Shift register datapath: parallel load, enabled bidirectional shift,
// serial in at the trailing end, serial out from the leading end.
module shift_dp
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] sreg
);

  logic [WIDTH-1:0] sreg_r;

  // Word register: load wins over shift; shift direction picks which end is fed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg_r <= {WIDTH{1'b0}};
    end else if (load) begin
      sreg_r <= load_data;
    end else if (shift_en) begin
      if (dir == DIR_MSB_FIRST) begin
        sreg_r <= {sreg_r[WIDTH-2:0], ser_in};
      end else begin
        sreg_r <= {ser_in, sreg_r[WIDTH-1:1]};
      end
    end else begin
      sreg_r <= sreg_r;
    end
  end

  assign ser_out = (dir == DIR_MSB_FIRST) ? sreg_r[WIDTH-1] : sreg_r[0];
  assign sreg    = sreg_r;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Full-duplex shift sequencer: accepts a word via valid/ready, shifts it
// out over WIDTH cycles while capturing WIDTH bits in, then pulses done.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             direc,
  input  logic             hold,
  input  logic             abort,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dir_q_r;
  logic [WIDTH-1:0] rx_data_r;
  logic             done_r;
  logic             busy_r;
  logic             start_ready_r;

  logic             load_s;
  logic             shift_en_s;
  logic             ser_out_s;
  logic             dp_out_s;
  logic [WIDTH-1:0] sreg_s;

  shift_dp #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (load_data),
    .shift_en  (shift_en_s),
    .dir       (dir_q_r),
    .ser_in    (ser_in),
    .ser_out   (dp_out_s),
    .sreg      (sreg_s)
  );

  // Datapath strobes and serial output; abort outranks hold and the final shift.
  always_comb begin
    load_s     = 1'b0;
    shift_en_s = 1'b0;
    ser_out_s  = 1'b0;
    case (state_r)
      IDLE: begin
        load_s = start_valid;
      end
      SHIFT: begin
        shift_en_s = ~hold & ~abort;
        ser_out_s  = dp_out_s;
      end
      DONE: begin
        load_s = 1'b0;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered handshake/status outputs and received word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      dir_q_r       <= DIR_LSB_FIRST;
      rx_data_r     <= {WIDTH{1'b0}};
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
      start_ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            state_r       <= SHIFT;
            dir_q_r       <= direc;
            cnt_r         <= {CNT_W{1'b0}};
            busy_r        <= 1'b1;
            start_ready_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            start_ready_r <= 1'b1;
          end else if (shift_en_s) begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r       <= IDLE;
          rx_data_r     <= sreg_s;
          done_r        <= 1'b0;
          busy_r        <= 1'b0;
          start_ready_r <= 1'b1;
        end
        default: begin
          state_r       <= IDLE;
          done_r        <= 1'b0;
          busy_r        <= 1'b0;
          start_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready = start_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign rx_data     = rx_data_r;
  assign shift_en    = shift_en_s;
  assign ser_out     = ser_out_s;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl (WIDTH=4).
module tb_shift_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [3:0] load_data;
  logic       direc;
  logic       hold;
  logic       abort;
  logic       ser_in;
  logic       ser_out;
  logic       shift_en;
  logic       busy;
  logic       done;
  logic [3:0] rx_data;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  shift_seq_ctrl #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .load_data   (load_data),
    .direc       (direc),
    .hold        (hold),
    .abort       (abort),
    .ser_in      (ser_in),
    .ser_out     (ser_out),
    .shift_en    (shift_en),
    .busy        (busy),
    .done        (done),
    .rx_data     (rx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One transfer: sin[i]/eout[i] are the i-th serial bits; hold inserted after hold_after shifts.
  task automatic run_xfer(input string tag, input logic [3:0] ld, input logic d,
                          input logic [3:0] sin, input logic [3:0] eout, input logic [3:0] erx,
                          input int hold_after, input int hold_len);
    int shifts;
    int held;
    int cyc;
    load_data   = ld;
    direc       = d;
    start_valid = 1'b1;
    #1;
    check_eq({tag, "_ready"}, 32'(start_ready), 32'd1);
    next_cycle();
    start_valid = 1'b0;
    shifts = 0;
    held   = 0;
    cyc    = 0;
    while (shifts < 4 && cyc < 20) begin
      if (shifts == hold_after && held < hold_len) begin
        hold        = 1'b1;
        start_valid = 1'b1;
        #1;
        check_eq({tag, "_hold_en"}, 32'(shift_en), 32'd0);
        check_eq({tag, "_hold_out"}, 32'(ser_out), 32'(eout[shifts]));
        check_eq({tag, "_hold_rdy"}, 32'(start_ready), 32'd0);
        held = held + 1;
      end else begin
        hold        = 1'b0;
        start_valid = 1'b0;
        ser_in      = sin[shifts];
        #1;
        check_eq({tag, "_out"}, 32'(ser_out), 32'(eout[shifts]));
        check_eq({tag, "_en"}, 32'(shift_en), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_nodone"}, 32'(done), 32'd0);
        shifts = shifts + 1;
      end
      next_cycle();
      cyc = cyc + 1;
    end
    hold        = 1'b0;
    start_valid = 1'b0;
    #1;
    check_eq({tag, "_lat"}, 32'(cyc), 32'(4 + hold_len));
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_done_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_done_out"}, 32'(ser_out), 32'd0);
    check_eq({tag, "_done_en"}, 32'(shift_en), 32'd0);
    next_cycle();
    check_eq({tag, "_post_done"}, 32'(done), 32'd0);
    check_eq({tag, "_post_ready"}, 32'(start_ready), 32'd1);
    check_eq({tag, "_post_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_rx"}, 32'(rx_data), 32'(erx));
  endtask

  initial begin
    rst         = 1'b0;
    start_valid = 1'b0;
    load_data   = 4'b0000;
    direc       = 1'b0;
    hold        = 1'b0;
    abort       = 1'b0;
    ser_in      = 1'b0;

    // Reset
    next_cycle();
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_ready", 32'(start_ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_out", 32'(ser_out), 32'd0);
      check_eq("rst_rx", 32'(rx_data), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      next_cycle();
    end

    // MSB first: 1001, in 0,1,1,0 -> out 1,0,0,1, rx 0110
    run_xfer("msb", 4'b1001, 1'b1, 4'b0110, 4'b1001, 4'b0110, 99, 0);

    // LSB first: 1011, in 1,0,0,1 -> out 1,1,0,1, rx 1001
    run_xfer("lsb", 4'b1011, 1'b0, 4'b1001, 4'b1011, 4'b1001, 99, 0);

    // Hold 3 cycles after 2 shifts: 1100, in 0,0,1,1 -> out 1,1,0,0, rx 0011
    run_xfer("hold", 4'b1100, 1'b1, 4'b1100, 4'b0011, 4'b0011, 2, 3);

    // Abort after 2 shifts; rx_data keeps 0011
    load_data   = 4'b1111;
    direc       = 1'b1;
    start_valid = 1'b1;
    next_cycle();
    start_valid = 1'b0;
    ser_in      = 1'b0;
    next_cycle();
    next_cycle();
    abort = 1'b1;
    #1;
    check_eq("abort_en", 32'(shift_en), 32'd0);
    next_cycle();
    abort = 1'b0;
    check_eq("abort_ready", 32'(start_ready), 32'd1);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_rx", 32'(rx_data), 32'(4'b0011));
    next_cycle();
    check_eq("abort_done2", 32'(done), 32'd0);

    // Transfer after abort: 0110 MSB, in 1,1,0,0 -> out 0,1,1,0, rx 1100
    run_xfer("post_abort", 4'b0110, 1'b1, 4'b0011, 4'b0110, 4'b1100, 99, 0);

    // Reset mid-transfer after one shift
    load_data   = 4'b1001;
    direc       = 1'b1;
    start_valid = 1'b1;
    next_cycle();
    start_valid = 1'b0;
    ser_in      = 1'b1;
    next_cycle();
    #2;
    rst = 1'b0;
    #1;
    check_eq("mrst_ready", 32'(start_ready), 32'd1);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_out", 32'(ser_out), 32'd0);
    check_eq("mrst_done", 32'(done), 32'd0);
    check_eq("mrst_rx", 32'(rx_data), 32'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    check_eq("mrst_done2", 32'(done), 32'd0);
    run_xfer("after_rst", 4'b1001, 1'b1, 4'b0110, 4'b1001, 4'b0110, 99, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
